// File: rtl/sweep_sequencer.sv
// ============================================================================
// sweep_sequencer
// ----------------------------------------------------------------------------
// Owns the count register of the WIDTH-bit up/down counter datapath and runs
// bounded triangle sweeps: lo -> hi -> lo, repeated ncycles times, then a
// one-cycle done pulse. Invalid configurations are rejected with an err pulse.
//
// Optional feature macro: SWEEP_DWELL_EN
//   When defined, a 4-bit dwell port and a HOLD state are added. The count is
//   held for 1+dwell cycles at hi, and at every lo turn point except the final
//   one. dwell=0 behaves exactly like the build without the macro.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous, active-high reset
//   start    in   launch a sweep (only accepted in IDLE)
//   abort    in   terminate an active sweep; count holds, no done
//   lo       in   lower bound, sampled on accepted start
//   hi       in   upper bound, sampled on accepted start
//   ncycles  in   number of triangles, sampled on accepted start
//   dwell    in   turn-point hold length (SWEEP_DWELL_EN only)
//   count    out  current count value (registered)
//   up_down  out  direction, 1 = up, 0 = down (registered)
//   busy     out  high while sweeping (registered)
//   done     out  one-cycle pulse on normal completion (registered)
//   err      out  one-cycle pulse on start with invalid config (registered)
// ============================================================================
module sweep_sequencer #(
    parameter int WIDTH  = 4,
    parameter int NCYC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [NCYC_W-1:0] ncycles,
`ifdef SWEEP_DWELL_EN
    input  logic [3:0]        dwell,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              up_down,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [WIDTH-1:0]  CNT_ONE = WIDTH'(1);
    localparam logic [NCYC_W-1:0] TRI_ONE = NCYC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
`ifdef SWEEP_DWELL_EN
        ,
        S_HOLD = 2'd3
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [WIDTH-1:0]    count_q,    count_d;
    logic                up_down_q,  up_down_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                err_q,      err_d;
    logic [NCYC_W-1:0]   tri_cnt_q,  tri_cnt_d;

    // Sweep configuration captured on an accepted start (datapath, no reset)
    logic [WIDTH-1:0]    lo_q,       lo_d;
    logic [WIDTH-1:0]    hi_q,       hi_d;
    logic [NCYC_W-1:0]   ncyc_q,     ncyc_d;

`ifdef SWEEP_DWELL_EN
    logic [3:0]          dwell_q,    dwell_d;
    // Remaining extra hold cycles, and whether the hold was entered at hi
    // (coming from UP) or at lo (coming from DOWN).
    logic [3:0]          hold_q,     hold_d;
    logic                hold_up_q,  hold_up_d;
`endif

    logic [NCYC_W-1:0]   tri_inc;
    logic                cfg_bad;

    assign tri_inc = tri_cnt_q + TRI_ONE;
    assign cfg_bad = (lo >= hi) || (ncycles == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tri_cnt_d = tri_cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        ncyc_d    = ncyc_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef SWEEP_DWELL_EN
        dwell_d   = dwell_q;
        hold_d    = hold_q;
        hold_up_d = hold_up_q;
`endif

        case (state_q)
            S_IDLE: begin
                // abort has no meaning here; start wins when both are high
                if (start) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d      = lo;
                        hi_d      = hi;
                        ncyc_d    = ncycles;
                        tri_cnt_d = '0;
                        count_d   = lo;
                        state_d   = S_UP;
`ifdef SWEEP_DWELL_EN
                        dwell_d   = dwell;
`endif
                    end
                end
            end

            S_UP: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    tri_cnt_d = '0;
                end else if (count_q < hi_q) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    // At hi: turn around without ever stepping past hi
`ifdef SWEEP_DWELL_EN
                    if (dwell_q != 4'd0) begin
                        state_d   = S_HOLD;
                        hold_d    = dwell_q - 4'd1;
                        hold_up_d = 1'b1;
                    end else begin
                        state_d = S_DOWN;
                        count_d = hi_q - CNT_ONE;
                    end
`else
                    state_d = S_DOWN;
                    count_d = hi_q - CNT_ONE;
`endif
                end
            end

            S_DOWN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    tri_cnt_d = '0;
                end else if (count_q > lo_q) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    // At lo: one triangle finished
                    tri_cnt_d = tri_inc;
                    if (tri_inc == ncyc_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
`ifdef SWEEP_DWELL_EN
                        if (dwell_q != 4'd0) begin
                            state_d   = S_HOLD;
                            hold_d    = dwell_q - 4'd1;
                            hold_up_d = 1'b0;
                        end else begin
                            state_d = S_UP;
                            count_d = lo_q + CNT_ONE;
                        end
`else
                        state_d = S_UP;
                        count_d = lo_q + CNT_ONE;
`endif
                    end
                end
            end

`ifdef SWEEP_DWELL_EN
            S_HOLD: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    tri_cnt_d = '0;
                end else if (hold_q == 4'd0) begin
                    // Hold over: take the step the turnaround deferred
                    if (hold_up_q) begin
                        state_d = S_DOWN;
                        count_d = hi_q - CNT_ONE;
                    end else begin
                        state_d = S_UP;
                        count_d = lo_q + CNT_ONE;
                    end
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs derived from the next state. During a hold
        // the direction keeps the value it had before the hold.
        busy_d    = (state_d != S_IDLE);
        up_down_d = (state_d != S_DOWN);
`ifdef SWEEP_DWELL_EN
        if (state_d == S_HOLD) begin
            up_down_d = hold_up_d;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            up_down_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tri_cnt_q <= '0;
`ifdef SWEEP_DWELL_EN
            hold_q    <= 4'd0;
            hold_up_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            up_down_q <= up_down_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tri_cnt_q <= tri_cnt_d;
`ifdef SWEEP_DWELL_EN
            hold_q    <= hold_d;
            hold_up_q <= hold_up_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Captured sweep configuration
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        lo_q   <= lo_d;
        hi_q   <= hi_d;
        ncyc_q <= ncyc_d;
`ifdef SWEEP_DWELL_EN
        dwell_q <= dwell_d;
`endif
    end

    assign count   = count_q;
    assign up_down = up_down_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
